line_span_engine: RTL and testbench

- Parametrised successor to the single-mode Bresenham line engine.
- Draws either a Bresenham line or a horizontal span fill into the frame buffer, with screen-bounds clipping.
- Sits between the CPU-side graphics command registers and the DDR address/write-data FIFO pair.
- Every burst is 256 bits (8 pixels): one address-FIFO write followed by two 128-bit write-data FIFO writes.

---
 rtl/line_span_engine_pkg.sv | 35 +++
 rtl/line_span_engine_if.sv | 22 ++
 rtl/line_span_engine_line_setup.sv | 40 ++++
 rtl/line_span_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_line_span_engine.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/line_span_engine_pkg.sv
// Shared types and helpers for the line/span frame-buffer engine.
package line_span_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SEND1 = 3'd2,
      ST_SEND2 = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int BURST_PIX = 8;
   localparam int BEAT_PIX  = 4;
   localparam logic [15:0] MASK_NONE = 16'hFFFF;

   // Byte mask for one 4-pixel beat; a set mask bit means the byte is not written.
   function automatic logic [15:0] beat_mask(input logic [3:0] en);
      logic [15:0] m;
      m = MASK_NONE;
      for (int i = 0; i < BEAT_PIX; i++) begin
         m[4*i +: 4] = {4{~en[i]}};
      end
      return m;
   endfunction

   function automatic logic [3:0] pop8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < BURST_PIX; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/line_span_engine_if.sv
// DDR address / write-data FIFO pair as seen by the engine.
interface line_span_engine_if #(
   parameter int ADDR_W = 31
) ();
   logic              af_full;
   logic              wdf_full;
   logic [ADDR_W-1:0] af_addr_din;
   logic              af_wr_en;
   logic [127:0]      wdf_din;
   logic [15:0]       wdf_mask_din;
   logic              wdf_wr_en;

   modport master (
      input  af_full, wdf_full,
      output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
   );

   modport slave (
      output af_full, wdf_full,
      input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
   );
endinterface

// File: rtl/line_span_engine_line_setup.sv
// Bresenham setup: steepness, octant swap, endpoint ordering and deltas.
module line_span_engine_line_setup #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0]        x0,
   input  logic [COORD_W-1:0]        y0,
   input  logic [COORD_W-1:0]        x1,
   input  logic [COORD_W-1:0]        y1,
   output logic                      steep,
   output logic [COORD_W-1:0]        xs,
   output logic [COORD_W-1:0]        ys,
   output logic [COORD_W-1:0]        xe,
   output logic [COORD_W-1:0]        dx,
   output logic [COORD_W-1:0]        dy,
   output logic signed [COORD_W:0]   err,
   output logic                      ystep_neg
);
   logic [COORD_W-1:0] adx_s, ady_s, a0_s, b0_s, a1_s, b1_s, ye_s;

   // Swap axes for steep lines, then order so the major axis runs upward.
   always_comb begin
      adx_s = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
      ady_s = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
      steep = (ady_s > adx_s);
      if (steep) begin
         a0_s = y0; b0_s = x0; a1_s = y1; b1_s = x1;
      end else begin
         a0_s = x0; b0_s = y0; a1_s = x1; b1_s = y1;
      end
      if (a0_s > a1_s) begin
         xs = a1_s; ys = b1_s; xe = a0_s; ye_s = b0_s;
      end else begin
         xs = a0_s; ys = b0_s; xe = a1_s; ye_s = b1_s;
      end
      dx        = xe - xs;
      dy        = (ye_s >= ys) ? (ye_s - ys) : (ys - ye_s);
      ystep_neg = (ys > ye_s);
      err       = $signed({2'b00, dx[COORD_W-1:1]});
   end
endmodule

// File: rtl/line_span_engine.sv
// Line / horizontal-span engine emitting 8-pixel bursts into the DDR FIFO pair.
module line_span_engine
   import line_span_engine_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int ADDR_W  = 31,
   parameter int H_RES   = 800,
   parameter int V_RES   = 600,
   parameter int CNT_W   = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 le_ready,
   input  logic [31:0]          le_color,
   input  logic [COORD_W-1:0]   le_point,
   input  logic                 le_color_valid,
   input  logic                 le_x0_valid,
   input  logic                 le_y0_valid,
   input  logic                 le_x1_valid,
   input  logic                 le_y1_valid,
   input  logic                 le_mode,
   input  logic                 le_trigger,
   input  logic [31:0]          le_frame_base,
   line_span_engine_if.master   fifo,
   output logic                 le_done,
   output logic [CNT_W-1:0]     le_pix_count
);
   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
   localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

   state_t state_r, state_nx;
   logic [31:0]        sh_color_r, color_r;
   logic [COORD_W-1:0] sh_x0_r, sh_y0_r, sh_x1_r, sh_y1_r;
   logic [COORD_W-1:0] wx0_r, wy0_r, wx1_r, wy1_r;
   logic               mode_r, steep_r, ystep_neg_r, clip_r, ready_r, done_r;
   logic [COORD_W-1:0] x_r, y_r, x_end_r, dx_r, dy_r;
   logic signed [COORD_W:0] err_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [15:0]        mask_r, mask_hi_r;
   logic [3:0]         cnt_r;
   logic [CNT_W-1:0]   pix_count_r;

   logic               su_steep, su_ystep_neg;
   logic [COORD_W-1:0] su_xs, su_ys, su_xe, su_dx, su_dy;
   logic signed [COORD_W:0] su_err;

   logic [COORD_W-1:0] base_x_s, adv_x_s, adv_y_s, span_lo_s, span_hi_s;
   logic signed [COORD_W:0] err_dec_s, adv_err_s, pos_err_s;
   logic               last_s;
   logic [COORD_W-1:0] pos_x_s, pos_y_s, pos_end_s, sx_s, sy_s, b_base_s, xp_s;
   logic               pos_steep_s, b_clip_s;
   logic [7:0]         span_en_s, pix_en_s;
   logic [ADDR_W-1:0]  b_addr_s;
   logic               af_en_s, wdf_en_s, load_burst_s, to_hi_s, add_cnt_s;
   logic               unused_s;

   assign unused_s = ^{le_frame_base[31:28], le_frame_base[21:0]};

   line_span_engine_line_setup #(.COORD_W(COORD_W)) u_line_setup (
      .x0(wx0_r), .y0(wy0_r), .x1(wx1_r), .y1(wy1_r),
      .steep(su_steep), .xs(su_xs), .ys(su_ys), .xe(su_xe),
      .dx(su_dx), .dy(su_dy), .err(su_err), .ystep_neg(su_ystep_neg)
   );

   // Step from the current pixel/burst to the next one and flag the final one.
   always_comb begin
      base_x_s  = {x_r[COORD_W-1:3], 3'b000};
      err_dec_s = err_r - $signed({1'b0, dy_r});
      span_lo_s = (wx0_r <= wx1_r) ? wx0_r : wx1_r;
      span_hi_s = (wx0_r <= wx1_r) ? wx1_r : wx0_r;
      adv_y_s   = y_r;
      adv_err_s = err_r;
      if (mode_r) begin
         last_s  = ((base_x_s + COORD_W'(7)) >= x_end_r);
         adv_x_s = base_x_s + COORD_W'(8);
      end else begin
         last_s  = (x_r == x_end_r);
         adv_x_s = x_r + COORD_W'(1);
         if (err_dec_s[COORD_W]) begin
            adv_y_s   = ystep_neg_r ? (y_r - COORD_W'(1)) : (y_r + COORD_W'(1));
            adv_err_s = err_dec_s + $signed({1'b0, dx_r});
         end else begin
            adv_y_s   = y_r;
            adv_err_s = err_dec_s;
         end
      end
   end

   // Position of the burst about to be loaded: fresh setup or the advanced one.
   always_comb begin
      pos_x_s     = adv_x_s;
      pos_y_s     = adv_y_s;
      pos_end_s   = x_end_r;
      pos_steep_s = steep_r;
      pos_err_s   = adv_err_s;
      if (state_r == ST_SETUP) begin
         if (mode_r) begin
            pos_x_s = span_lo_s; pos_y_s = wy0_r; pos_end_s = span_hi_s;
            pos_steep_s = 1'b0;  pos_err_s = err_r;
         end else begin
            pos_x_s = su_xs; pos_y_s = su_ys; pos_end_s = su_xe;
            pos_steep_s = su_steep; pos_err_s = su_err;
         end
      end else begin
         pos_x_s = adv_x_s;
         pos_y_s = adv_y_s;
      end
   end

   // Screen coordinates, pixel enables, clipping and address for that burst.
   always_comb begin
      sx_s      = pos_steep_s ? pos_y_s : pos_x_s;
      sy_s      = pos_steep_s ? pos_x_s : pos_y_s;
      b_base_s  = {sx_s[COORD_W-1:3], 3'b000};
      span_en_s = 8'h00;
      xp_s      = b_base_s;
      for (int p = 0; p < BURST_PIX; p++) begin
         xp_s = b_base_s + COORD_W'(p);
         span_en_s[p] = (xp_s >= pos_x_s) && (xp_s <= pos_end_s) && ({1'b0, xp_s} < H_LIM);
      end
      if (mode_r) begin
         pix_en_s = span_en_s;
         b_clip_s = ({1'b0, sy_s} >= V_LIM) || ({1'b0, pos_x_s} >= H_LIM);
      end else begin
         pix_en_s = 8'b0000_0001 << sx_s[2:0];
         b_clip_s = ({1'b0, sy_s} >= V_LIM) || ({1'b0, sx_s} >= H_LIM);
      end
      b_addr_s = ADDR_W'({le_frame_base[27:22], sy_s, sx_s[COORD_W-1:3], 2'b00});
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // FSM next state and FIFO strobes.
   always_comb begin
      state_nx     = state_r;
      af_en_s      = 1'b0;
      wdf_en_s     = 1'b0;
      load_burst_s = 1'b0;
      to_hi_s      = 1'b0;
      add_cnt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (le_trigger) state_nx = ST_SETUP;
            else            state_nx = ST_IDLE;
         end
         ST_SETUP: begin
            load_burst_s = 1'b1;
            state_nx     = ST_SEND1;
         end
         ST_SEND1: begin
            if (clip_r) begin
               if (last_s) state_nx = ST_DONE;
               else        load_burst_s = 1'b1;
            end else if (!fifo.af_full && !fifo.wdf_full) begin
               af_en_s  = 1'b1;
               wdf_en_s = 1'b1;
               to_hi_s  = 1'b1;
               state_nx = ST_SEND2;
            end else begin
               state_nx = ST_SEND1;
            end
         end
         ST_SEND2: begin
            if (!fifo.wdf_full) begin
               wdf_en_s  = 1'b1;
               add_cnt_s = 1'b1;
               if (last_s) begin
                  state_nx = ST_DONE;
               end else begin
                  load_burst_s = 1'b1;
                  state_nx     = ST_SEND1;
               end
            end else begin
               state_nx = ST_SEND2;
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Shadow registers, trigger capture and the per-draw working state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_color_r <= 32'd0;
         sh_x0_r <= {COORD_W{1'b0}}; sh_y0_r <= {COORD_W{1'b0}};
         sh_x1_r <= {COORD_W{1'b0}}; sh_y1_r <= {COORD_W{1'b0}};
         color_r <= 32'd0; mode_r <= 1'b0;
         wx0_r <= {COORD_W{1'b0}}; wy0_r <= {COORD_W{1'b0}};
         wx1_r <= {COORD_W{1'b0}}; wy1_r <= {COORD_W{1'b0}};
         x_r <= {COORD_W{1'b0}}; y_r <= {COORD_W{1'b0}}; x_end_r <= {COORD_W{1'b0}};
         dx_r <= {COORD_W{1'b0}}; dy_r <= {COORD_W{1'b0}};
         err_r <= {(COORD_W+1){1'b0}}; steep_r <= 1'b0; ystep_neg_r <= 1'b0;
      end else begin
         if (le_color_valid) sh_color_r <= le_color;
         if (le_x0_valid)    sh_x0_r <= le_point;
         if (le_y0_valid)    sh_y0_r <= le_point;
         if (le_x1_valid)    sh_x1_r <= le_point;
         if (le_y1_valid)    sh_y1_r <= le_point;
         if (state_r == ST_IDLE && le_trigger) begin
            color_r <= sh_color_r; mode_r <= le_mode;
            wx0_r <= sh_x0_r; wy0_r <= sh_y0_r; wx1_r <= sh_x1_r; wy1_r <= sh_y1_r;
         end
         if (state_r == ST_SETUP) begin
            dx_r <= su_dx; dy_r <= su_dy; ystep_neg_r <= su_ystep_neg;
         end
         if (load_burst_s) begin
            x_r <= pos_x_s; y_r <= pos_y_s; x_end_r <= pos_end_s;
            steep_r <= pos_steep_s; err_r <= pos_err_s;
         end
      end
   end

   // Registered burst outputs, pixel counter and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r <= {ADDR_W{1'b0}}; mask_r <= MASK_NONE; mask_hi_r <= MASK_NONE;
         clip_r <= 1'b0; cnt_r <= 4'd0; pix_count_r <= {CNT_W{1'b0}};
         ready_r <= 1'b1; done_r <= 1'b0;
      end else begin
         if (load_burst_s) begin
            addr_r    <= b_addr_s;
            mask_r    <= beat_mask(pix_en_s[3:0]);
            mask_hi_r <= beat_mask(pix_en_s[7:4]);
            clip_r    <= b_clip_s;
            cnt_r     <= pop8(pix_en_s);
         end else if (to_hi_s) begin
            mask_r <= mask_hi_r;
         end
         if (state_r == ST_IDLE && le_trigger) pix_count_r <= {CNT_W{1'b0}};
         else if (add_cnt_s)                   pix_count_r <= pix_count_r + CNT_W'(cnt_r);
         ready_r <= (state_nx == ST_IDLE);
         done_r  <= (state_nx == ST_DONE);
      end
   end

   assign fifo.af_addr_din  = addr_r;
   assign fifo.af_wr_en     = af_en_s;
   assign fifo.wdf_din      = {4{color_r}};
   assign fifo.wdf_mask_din = mask_r;
   assign fifo.wdf_wr_en    = wdf_en_s;
   assign le_ready          = ready_r;
   assign le_done           = done_r;
   assign le_pix_count      = pix_count_r;
endmodule

// File: tb/tb_line_span_engine.sv
// Directed bench for line_span_engine: lines, steep lines, spans, clipping, backpressure, reset.
module tb_line_span_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        le_ready, le_done;
   logic [31:0] le_color = 32'd0;
   logic [9:0]  le_point = 10'd0;
   logic        le_color_valid = 1'b0, le_x0_valid = 1'b0, le_y0_valid = 1'b0;
   logic        le_x1_valid = 1'b0, le_y1_valid = 1'b0;
   logic        le_mode = 1'b0, le_trigger = 1'b0;
   logic [31:0] le_frame_base = 32'h0AC0_0000;
   logic [19:0] le_pix_count;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int viol = 0;
   int done_before;
   logic [30:0]  aq[$];
   logic [15:0]  mq[$];
   logic [127:0] dq[$];
   int sxs[7] = '{5, 5, 6, 6, 6, 7, 7};

   line_span_engine_if #(.ADDR_W(31)) fif ();

   line_span_engine dut (
      .clk(clk), .rst(rst), .le_ready(le_ready), .le_color(le_color), .le_point(le_point),
      .le_color_valid(le_color_valid), .le_x0_valid(le_x0_valid), .le_y0_valid(le_y0_valid),
      .le_x1_valid(le_x1_valid), .le_y1_valid(le_y1_valid), .le_mode(le_mode),
      .le_trigger(le_trigger), .le_frame_base(le_frame_base), .fifo(fif),
      .le_done(le_done), .le_pix_count(le_pix_count)
   );

   always #5 clk = ~clk;

   // FIFO-side monitor: records every accepted write and any protocol violation.
   always @(negedge clk) begin
      if (!rst) begin
         if (fif.af_wr_en) aq.push_back(fif.af_addr_din);
         if (fif.wdf_wr_en) begin
            mq.push_back(fif.wdf_mask_din);
            dq.push_back(fif.wdf_din);
         end
         if (le_done) done_cnt++;
         if ((fif.af_wr_en && fif.af_full) || (fif.wdf_wr_en && fif.wdf_full) ||
             (fif.af_wr_en && !fif.wdf_wr_en)) viol++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [30:0] exp_addr(input int sx, input int sy);
      logic [9:0] x, y;
      logic [31:0] fb;
      x = 10'(sx); y = 10'(sy); fb = le_frame_base;
      return 31'({fb[27:22], y, x[9:3], 2'b00});
   endfunction

   function automatic logic [15:0] lmask(input int lane);
      logic [15:0] m;
      m = 16'hFFFF;
      m[4*lane +: 4] = 4'h0;
      return m;
   endfunction

   function automatic logic [30:0] a_at(input int i);
      if (i < aq.size()) return aq[i];
      else return {31{1'bx}};
   endfunction

   function automatic logic [15:0] m_at(input int i);
      if (i < mq.size()) return mq[i];
      else return {16{1'bx}};
   endfunction

   task automatic load_cmd(input int x0, input int y0, input int x1, input int y1, input logic [31:0] c);
      le_color = c; le_color_valid = 1'b1;
      le_point = 10'(x0); le_x0_valid = 1'b1; tick(); le_x0_valid = 1'b0; le_color_valid = 1'b0;
      le_point = 10'(y0); le_y0_valid = 1'b1; tick(); le_y0_valid = 1'b0;
      le_point = 10'(x1); le_x1_valid = 1'b1; tick(); le_x1_valid = 1'b0;
      le_point = 10'(y1); le_y1_valid = 1'b1; tick(); le_y1_valid = 1'b0;
   endtask

   task automatic start(input logic m);
      aq.delete(); mq.delete(); dq.delete(); done_cnt = 0; viol = 0;
      le_mode = m; le_trigger = 1'b1; tick(); le_trigger = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clk);
         if (le_done) seen = 1'b1;
         n++;
      end
      chk(tag, seen, 1'b1);
      tick(); tick();
   endtask

   initial begin
      fif.af_full = 1'b0; fif.wdf_full = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ready", le_ready, 1'b1);
      chk("rst_done", le_done, 1'b0);
      chk("rst_af_en", fif.af_wr_en, 1'b0);
      chk("rst_wdf_en", fif.wdf_wr_en, 1'b0);
      chk("rst_mask", fif.wdf_mask_din, 16'hFFFF);
      chk("rst_addr", fif.af_addr_din, 31'd0);
      chk("rst_count", le_pix_count, 20'd0);
      tick(); rst = 1'b0; tick();

      // Horizontal line (0,0)-(3,0)
      load_cmd(0, 0, 3, 0, 32'h00FF_0000);
      start(1'b0);
      wait_done("t1_done");
      chk("t1_nbursts", aq.size(), 4);
      chk("t1_nbeats", mq.size(), 8);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", a_at(i), exp_addr(0, 0));
         chk("t1_mask0", m_at(2*i), lmask(i));
         chk("t1_mask1", m_at(2*i+1), 16'hFFFF);
      end
      chk("t1_data", (dq.size() > 0) ? dq[0] : 128'd0, {4{32'h00FF_0000}});
      chk("t1_count", le_pix_count, 20'd4);
      chk("t1_done_once", done_cnt, 1);

      // Steep line (5,0)-(7,6)
      load_cmd(5, 0, 7, 6, 32'h0012_3456);
      start(1'b0);
      wait_done("t2_done");
      chk("t2_nbursts", aq.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk("t2_addr", a_at(i), exp_addr(sxs[i], i));
         chk("t2_mask0", m_at(2*i), 16'hFFFF);
         chk("t2_mask1", m_at(2*i+1), lmask(sxs[i] - 4));
      end
      chk("t2_count", le_pix_count, 20'd7);

      // Span x 2..13 at y 10, endpoints given high-to-low
      load_cmd(13, 10, 2, 10, 32'h0000_00FF);
      start(1'b1);
      wait_done("t3_done");
      chk("t3_nbursts", aq.size(), 2);
      chk("t3_addr0", a_at(0), exp_addr(0, 10));
      chk("t3_addr1", a_at(1), exp_addr(8, 10));
      chk("t3_m0", m_at(0), 16'h00FF);
      chk("t3_m1", m_at(1), 16'h0000);
      chk("t3_m2", m_at(2), 16'h0000);
      chk("t3_m3", m_at(3), 16'hFF00);
      chk("t3_count", le_pix_count, 20'd12);

      // Line crossing the right screen edge
      load_cmd(795, 5, 805, 5, 32'h0000_FF00);
      start(1'b0);
      wait_done("t4_done");
      chk("t4_nbursts", aq.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("t4_addr", a_at(i), exp_addr(795 + i, 5));
      end
      chk("t4_m0", m_at(0), lmask(3));
      chk("t4_m1", m_at(1), 16'hFFFF);
      chk("t4_m3", m_at(3), lmask(0));
      chk("t4_count", le_pix_count, 20'd5);
      chk("t4_done_once", done_cnt, 1);

      // Backpressure on a single-point line
      load_cmd(2, 3, 2, 3, 32'h00AB_CDEF);
      fif.af_full = 1'b1;
      start(1'b0);
      repeat (9) tick();
      @(negedge clk);
      chk("t5_af_stall", fif.af_wr_en, 1'b0);
      chk("t5_wdf_stall", fif.wdf_wr_en, 1'b0);
      chk("t5_addr_hold", fif.af_addr_din, exp_addr(2, 3));
      chk("t5_mask_hold", fif.wdf_mask_din, lmask(2));
      tick();
      fif.af_full = 1'b0;
      tick();
      fif.wdf_full = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("t5_wdf_stall2", fif.wdf_wr_en, 1'b0);
      chk("t5_mask1_hold", fif.wdf_mask_din, 16'hFFFF);
      tick();
      fif.wdf_full = 1'b0;
      wait_done("t5_done");
      chk("t5_naf", aq.size(), 1);
      chk("t5_nwdf", mq.size(), 2);
      chk("t5_m0", m_at(0), lmask(2));
      chk("t5_viol", viol, 0);
      chk("t5_count", le_pix_count, 20'd1);

      // Reset in the middle of a long line, then redraw
      load_cmd(0, 0, 100, 0, 32'h0055_5555);
      start(1'b0);
      repeat (20) tick();
      done_before = done_cnt;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_ready", le_ready, 1'b1);
      chk("t6_af_en", fif.af_wr_en, 1'b0);
      chk("t6_wdf_en", fif.wdf_wr_en, 1'b0);
      chk("t6_done", le_done, 1'b0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("t6_no_done", done_cnt, done_before);
      load_cmd(10, 20, 12, 20, 32'h0011_2233);
      start(1'b0);
      wait_done("t6b_done");
      chk("t6b_nbursts", aq.size(), 3);
      chk("t6b_addr0", a_at(0), exp_addr(10, 20));
      chk("t6b_m0", m_at(0), lmask(2));
      chk("t6b_count", le_pix_count, 20'd3);
      chk("t6b_done_once", done_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
